sprite_blitter: RTL

Copies one SPR_W×SPR_H sprite from a synchronous sprite ROM into the VGA framebuffer at screen position (startX, startY), one pixel write per handshake. It is the write-side counterpart of the window/address decoder used during scan-out: it applies the same 640-wide linear addressing with 1-based rows, so a sprite blitted at (X, Y) is read back by the scan-out path at the same (X, Y). It sits between the game logic, which issues start, and the framebuffer write port.

---
 rtl/tetris_vga_pkg.sv | 13 +
 rtl/blit_coord_gen.sv | 47 ++++
 rtl/sprite_blitter.sv | 80 ++++++++
 3 files changed

// File: rtl/tetris_vga_pkg.sv
// tetris_vga_pkg: screen/sprite geometry constants and blitter state type
package tetris_vga_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPR_W = 64;
  localparam int SPR_H = 48;
  localparam int ADDR_W = 19;
  localparam int COLOR_W = 8;
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam logic [COLOR_W-1:0] TRANSPARENT_COLOR = 8'h00;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} blit_state_t;
endpackage

// File: rtl/blit_coord_gen.sv
// blit_coord_gen: sprite r/c counters, screen row/col, clip test, ROM and framebuffer addresses
// Ports: clock, resetn (sync, active-low); load latches start_x/start_y and clears r/c;
// step advances c then r; src_addr = r*SPR_W+c; fb_addr = row*SCREEN_W+col;
// visible = pixel lies on screen; last = r/c at the final sprite pixel.
module blit_coord_gen
  import tetris_vga_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic              step,
  input  logic [9:0]        start_x,
  input  logic [9:0]        start_y,
  output logic [11:0]       src_addr,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              visible,
  output logic              last
);
  logic [9:0] x, y;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [10:0] row, col;
  logic c_last;
  always_ff @(posedge clock)
    if (!resetn) begin
      x <= '0;
      y <= '0;
      r <= '0;
      c <= '0;
    end else if (load) begin
      x <= start_x;
      y <= start_y;
      r <= '0;
      c <= '0;
    end else if (step) begin
      c <= c_last ? '0 : c + 1'b1;
      r <= c_last ? r + 1'b1 : r;
    end
  // rows are 1-based: startY=0 with r=0 wraps to 2047 and is clipped
  assign row = 11'(y) + 11'(r) - 11'd1;
  assign col = 11'(x) + 11'(c);
  assign visible = row < 11'(SCREEN_H) && col < 11'(SCREEN_W);
  assign c_last = c == CW'(SPR_W - 1);
  assign last = c_last && r == RW'(SPR_H - 1);
  assign src_addr = 12'(r) * 12'(SPR_W) + 12'(c);
  assign fb_addr = ADDR_W'(row) * ADDR_W'(SCREEN_W) + ADDR_W'(col);
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one sprite from ROM into the framebuffer at (startX, startY), clipped to the screen
// Ports: clock, resetn (sync, active-low); start/startX/startY request; src_addr/src_data sprite ROM
// (1-cycle latency); fb_we/fb_addr/fb_data/fb_ready framebuffer write handshake; busy, done status.
// Option: define BLIT_TRANSPARENCY_EN to skip writes of TRANSPARENT_COLOR pixels.
module sprite_blitter
  import tetris_vga_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [9:0]         startX,
  input  logic [9:0]         startY,
  output logic [11:0]        src_addr,
  input  logic [COLOR_W-1:0] src_data,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  input  logic               fb_ready,
  output logic               busy,
  output logic               done
);
  blit_state_t state, state_nx;
  logic we_q, we_nx, load, step, visible, last, skip, accept;
  logic [ADDR_W-1:0] addr;
  blit_coord_gen u_coord (
    .clock   (clock),
    .resetn  (resetn),
    .load    (load),
    .step    (step),
    .start_x (startX),
    .start_y (startY),
    .src_addr(src_addr),
    .fb_addr (addr),
    .visible (visible),
    .last    (last)
  );
`ifdef BLIT_TRANSPARENCY_EN
  assign skip = state == WR && src_data == TRANSPARENT_COLOR;
`else
  assign skip = 1'b0;
`endif
  // a transparent pixel suppresses the pending write and completes at once
  assign fb_we = we_q && !skip;
  assign accept = (we_q && fb_ready) || skip;
  assign fb_addr = state == WR ? addr : '0;
  assign fb_data = state == WR ? src_data : '0;
  assign busy = state == RD || state == WR;
  assign done = state == DONE;
  always_ff @(posedge clock)
    if (!resetn) begin
      state <= IDLE;
      we_q <= 1'b0;
    end else begin
      state <= state_nx;
      we_q <= we_nx;
    end
  always_comb begin
    state_nx = state;
    we_nx = we_q;
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: begin
        load = start;
        state_nx = start ? RD : IDLE;
      end
      RD: begin
        step = !visible;
        we_nx = visible;
        state_nx = visible ? WR : (last ? DONE : RD);
      end
      WR: begin
        step = accept;
        we_nx = we_q && !accept;
        state_nx = accept ? (last ? DONE : RD) : WR;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule
